// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
// Queue entries carry the fetch PC alongside the returned instruction word.
package if_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } if_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } if_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// In-order prefetch queue with a registered head entry.
// Push and pop may coincide at any fill level; flush empties it in one cycle.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  if_entry_t        push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output if_entry_t        head
);

    if_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    if_entry_t        head_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The head register must show the entry that will sit at rd_ptr after this
    // edge; when that slot is being written right now, take it from push_data.
    always_comb begin
        rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        count_nxt  = count + CNT_W'(do_push) - CNT_W'(do_pop);
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (do_push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = push_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            head   <= head_nxt;
        end
    end

    // NOTE: payload storage is not reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: credit-limited prefetch into an in-order queue,
// valid/ready hand-off to decode, and redirect flush with stale-response drop.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    if_state_t         state_q;
    if_state_t         state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q;
    logic [ADDR_W-1:0] rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_d;
    logic [ADDR_W-1:0] target_pc;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    if_entry_t         push_entry;
    if_entry_t         head;

    logic [SUM_W-1:0]  credits_used;
    logic              req_fire;
    logic              rsp_fire;

    // Queued entries plus in-flight fetches never exceed the queue depth, so
    // every response has a slot waiting for it.
    assign credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = (state_q == FETCH) && (credits_used < SUM_W'(DEPTH)) && !rst;
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_fire  = imem_rsp_valid;
    assign target_pc = word_align(redirect_pc);

    assign fifo_push  = rsp_fire && (state_q == FETCH) && !redirect;
    assign fifo_pop   = id_valid && id_ready;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign id_valid = !fifo_empty;
    assign id_pc    = head.pc;
    assign id_instr = head.instr;

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        if (redirect) begin
            // Everything still in flight after this edge belongs to the old stream.
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            drop_cnt_d = outstanding_d;
            state_d    = (outstanding_d != '0) ? FLUSH : FETCH;
        end else if (state_q == FETCH) begin
            if (rsp_fire) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
        end else begin
            if (rsp_fire && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (drop_cnt_d == '0) begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // A response into a full queue means the memory broke the credit contract.
    a_no_overflow: assert property (@(posedge clk)
        (!rst && imem_rsp_valid && (state_q == FETCH) && !redirect) |-> !fifo_full);

    // While flushing, every in-flight fetch is stale and still owed a response.
    a_flush_count: assert property (@(posedge clk)
        (!rst && (state_q == FLUSH)) |-> ((drop_cnt_q == outstanding_q) && (drop_cnt_q != '0)));

    a_req_stable: assert property (@(posedge clk)
        (!rst && imem_req_valid && !imem_req_ready && !redirect)
        |=> (rst || (imem_req_valid && $stable(imem_req_addr))));

    a_addr_aligned: assert property (@(posedge clk)
        imem_req_valid |-> (imem_req_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench: variable-latency memory model, stream scoreboard for
// decode hand-offs and fetch addresses, directed scenarios then random traffic.
module tb_if_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        redirect;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend_q[$];
    int    cyc       = 0;
    int    mem_lat   = 1;
    int    ready_pct = 100;

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_q.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            end
            @(posedge clk);
            cyc++;
            #1;
            imem_req_ready = ($urandom_range(99) < ready_pct);
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    // After reset or a redirect to T, decode must see T, T+4, T+8, ... with the
    // matching instructions, and fetch requests must walk the same sequence.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] gen_pc;
    logic [31:0] req_exp_pc;
    int          req_fires  = 0;
    int          handshakes = 0;
    logic        seen_first;
    logic [31:0] first_pc;

    task automatic restart_stream(input logic [31:0] target);
        exp_q.delete();
        gen_pc     = target;
        req_exp_pc = target;
        seen_first = 1'b0;
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: gen_pc, instr: instr_of(gen_pc)});
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    initial begin
        restart_stream(RESET_PC);
        forever begin
            @(negedge clk);
            if (rst) begin
                restart_stream(RESET_PC);
                continue;
            end
            refill();
            if (id_valid) begin
                check("id_pc", id_pc, exp_q[0].pc);
                check("id_instr", id_instr, exp_q[0].instr);
                if (!seen_first) begin
                    seen_first = 1'b1;
                    first_pc   = id_pc;
                end
                if (id_ready) begin
                    void'(exp_q.pop_front());
                    handshakes++;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, req_exp_pc);
                req_exp_pc = req_exp_pc + 32'd4;
                req_fires++;
            end
            if (redirect) begin
                restart_stream({redirect_pc[31:2], 2'b00});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst      = 1'b1;
        redirect = 1'b0;
        @(negedge clk);
        check("rst_req_valid_comb", imem_req_valid, 1'b0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect    = 1'b0;
        redirect_pc = $urandom;
    endtask

    // Wait (bounded) until the monitor has seen the first head of the new stream.
    task automatic expect_first(input string name, input logic [31:0] exp_pc);
        int n = 0;
        while (!seen_first && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, seen_first ? first_pc : 32'hDEAD_DEAD, exp_pc);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t_req;
        int t_rsp;
        int t_id;
        int r0;
        int h0;
        logic found;

        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;

        // 1: zero-wait memory, decode always ready
        mem_lat = 1; ready_pct = 100; id_ready = 1'b1;
        apply_reset(2);
        t_req = -1; t_rsp = -1; t_id = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t_req < 0 && imem_req_valid && imem_req_ready) t_req = i;
            if (t_rsp < 0 && imem_rsp_valid) t_rsp = i;
            if (t_id < 0 && id_valid) t_id = i;
        end
        check("lat_req_to_id", 32'(t_id - t_req), 32'd2);
        check("lat_rsp_to_id", 32'(t_id - t_rsp), 32'd1);
        check("stream_progress", 32'(handshakes >= 15), 32'd1);

        // 2: decode stalled -> exactly DEPTH fetches, then resume at 0x10
        id_ready = 1'b0;
        apply_reset(1);
        r0 = req_fires;
        repeat (12) tick();
        @(negedge clk);
        check("credit_req_count", 32'(req_fires - r0), 32'(DEPTH));
        check("credit_req_valid", imem_req_valid, 1'b0);
        check("credit_id_valid", id_valid, 1'b1);
        tick();
        id_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                check("resume_addr", imem_req_addr, 32'h10);
            end
        end
        check("resume_seen", found, 1'b1);
        repeat (10) tick();

        // 3: 3-cycle memory, redirect to mis-aligned 0x102 with fetches in flight
        mem_lat = 3;
        apply_reset(1);
        tick();
        do_redirect(32'h0000_0102);
        expect_first("flush_first_pc", 32'h100);
        repeat (10) tick();

        // 4: redirect coinciding with a request fire and a response beat
        mem_lat = 1;
        repeat (6) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        check("coincident_fire", 32'(imem_req_valid && imem_req_ready && imem_rsp_valid), 32'd1);
        tick();
        redirect = 1'b0;
        expect_first("coincident_first_pc", 32'h300);
        repeat (8) tick();

        // 5: second redirect while still flushing
        mem_lat = 3;
        repeat (6) tick();
        do_redirect(32'h0000_0100);
        do_redirect(32'h0000_0200);
        expect_first("reflush_first_pc", 32'h200);
        repeat (10) tick();

        // 6: reset mid-stream with a full queue
        mem_lat = 1; id_ready = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        check("full_before_rst", 32'(id_valid && !imem_req_valid), 32'd1);
        tick();
        apply_reset(1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                check("post_rst_addr", imem_req_addr, RESET_PC);
            end
        end
        check("post_rst_seen", found, 1'b1);
        id_ready = 1'b1;
        repeat (6) tick();

        // 7: fetch address wrap FFFF_FFFC -> 0
        do_redirect(32'hFFFF_FFF6);
        expect_first("wrap_first_pc", 32'hFFFF_FFF4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (id_valid && id_pc == 32'h0) found = 1'b1;
        end
        check("wrap_reached_zero", found, 1'b1);
        repeat (4) tick();

        // 8: random traffic
        h0 = handshakes;
        for (int ph = 0; ph < 30; ph++) begin
            mem_lat   = $urandom_range(1, 4);
            ready_pct = $urandom_range(30, 100);
            for (int c = 0; c < 100; c++) begin
                id_ready = ($urandom_range(3) != 0);
                if ($urandom_range(399) == 0) begin
                    rst = 1'b1;
                    tick();
                    tick();
                    rst = 1'b0;
                end else if ($urandom_range(24) == 0) begin
                    do_redirect($urandom);
                end else begin
                    tick();
                end
            end
        end
        check("random_progress", 32'(handshakes - h0 > 300), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
